// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to packed BCD converter with start/done handshake.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report its sign on neg.
module bin2bcd_seq #(
    parameter int W      = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  neg
);

    localparam int          BW      = 4 * DIGITS;
    localparam int          SW      = BW + 4;
    localparam int          CW      = $clog2(W + 1);
    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);

    // Handshake: start is accepted only on a clock edge where state is IDLE;
    // done is a one-cycle pulse in DONE and bcd/overflow/neg hold until the next DONE.
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [W-1:0]    bin_reg, bin_next;
    logic [SW-1:0]   scratch, scratch_adj, scratch_next;
    logic [W-1:0]    mag;
    logic            mag_over;
    logic            ovf_cap;
    logic            result_ovf;
    logic [BW-1:0]   result_bcd;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;

`ifdef BIN2BCD_SIGNED_EN
    logic is_neg, neg_cap, neg_q;
    assign is_neg = bin[W-1];
    assign mag    = is_neg ? (~bin + W'(1)) : bin;
    assign neg    = neg_q;
`else
    assign mag = bin;
    assign neg = 1'b0;
`endif

    assign mag_over = 32'(mag) > MAX_VAL;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < SW / 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch_adj[SW-2:0], bin_reg[W-1]};
        bin_next     = {bin_reg[W-2:0], 1'b0};
    end

    assign result_ovf = ovf_cap | (|scratch_next[SW-1:BW]);
    assign result_bcd = result_ovf ? {DIGITS{4'h9}} : scratch_next[BW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            bin_reg <= '0;
            scratch <= '0;
            ovf_cap <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_cap <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                bin_reg <= mag;
                scratch <= '0;
                count   <= CW'(W);
                ovf_cap <= mag_over;
`ifdef BIN2BCD_SIGNED_EN
                neg_cap <= is_neg;
`endif
            end
            if (state == SHIFT) begin
                scratch <= scratch_next;
                bin_reg <= bin_next;
                count   <= count - 1'b1;
                // Results are latched on the edge that enters DONE.
                if (count == CW'(1)) begin
                    bcd_q <= result_bcd;
                    ovf_q <= result_ovf;
`ifdef BIN2BCD_SIGNED_EN
                    neg_q <= neg_cap;
`endif
                end
            end
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected {neg, overflow, bcd} queued at start, popped on each done.
// Signed cases run when BIN2BCD_SIGNED_EN is defined.
module tb_bin2bcd_seq;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  bin = '0;
    logic          busy, done, overflow, neg;
    logic [15:0]   bcd;

    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;
    int            n_conv = 0;
    logic [17:0]   exp_q[$];
    logic [17:0]   last_exp;

    bin2bcd_seq #(.W(W), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .neg(neg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits by integer arithmetic, saturating above 9999.
    function automatic logic [17:0] model(input logic [W-1:0] v);
        int   mag;
        logic n;
        n   = 1'b0;
        mag = int'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[W-1]) begin
            n   = 1'b1;
            mag = (1 << W) - int'(v);
        end
`endif
        if (mag > 9999) return {n, 1'b1, 16'h9999};
        return {n, 1'b0, 4'(mag / 1000), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] v);
        exp_q.push_back(model(v));
        last_exp = model(v);
        n_conv++;
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("result", {14'd0, neg, overflow, bcd}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic convert(input logic [W-1:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        bin   = W'($urandom_range(0, (1 << W) - 1));
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold", {14'd0, neg, overflow, bcd}, {14'd0, last_exp});
    endtask

    initial begin
        logic [W-1:0] v;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);

        // Cycle-accurate latency of a single conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = W'(1234);
        push_exp(W'(1234));
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            check($sformatf("lat_busy_%0d", j), 32'(busy), 32'(j <= 15));
            check($sformatf("lat_done_%0d", j), 32'(done), 32'(j == 15));
        end
        check("bcd_1234", 32'(bcd), 32'h1234);

        // Back-to-back: start held, second value taken the cycle after DONE.
        @(negedge clk);
        start = 1'b1;
        bin   = W'(0);
        push_exp(W'(0));
        @(negedge clk);
        bin = W'(9999);
        push_exp(W'(9999));
        repeat (16) @(negedge clk);
        start = 1'b0;
        wait_idle();

        convert(W'(10000));
        convert(W'(16383));
        convert(W'(42));

        // start held for 20 cycles with bin changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 20; n++) begin
            v   = W'($urandom_range(0, (1 << W) - 1));
            bin = v;
            if (n == 0 || n == 16) push_exp(v);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        for (int r = 0; r < 4; r++) begin
            convert(W'($urandom_range(0, 9999)));
        end
        convert(W'(5678));

        // Reset seven cycles into a conversion discards it.
        @(negedge clk);
        start = 1'b1;
        bin   = W'(5555);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        repeat (20) @(negedge clk);
        check("mid_rst_bcd_late", 32'(bcd), 32'd0);

`ifdef BIN2BCD_SIGNED_EN
        convert(W'(14'h3FD6));
        check("signed_m42", {14'd0, neg, overflow, bcd}, {14'd0, 2'b10, 16'h0042});
        convert(W'(14'h2000));
        check("signed_m8192", {14'd0, neg, overflow, bcd}, {14'd0, 2'b10, 16'h8192});
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(n_conv));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) converter from binary to packed BCD.
- Sits directly upstream of the 4-digit seven-segment driver and feeds its 16-bit data input when decimal display is selected.
- Handles one value at a time using a start/done handshake, and holds the last result stable for the display.

Parameters:
- W, 14, width of binary input (unsigned magnitude; 2..16)
- DIGITS, 4, number of BCD output digits

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bin  input  W  binary value; captured on the accepted start edge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, result valid
- bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; holds last result
- overflow  output  1  last result saturated; held with bcd
- neg  output  1  sign of last result (see Optional Feature)

Behaviour:
- Reset (rst high at clk edge):
  - State goes to IDLE.
  - busy=0, done=0, bcd=0, overflow=0, neg=0.
  - Internal shift/scratch registers cleared.
  - Reset has priority over all other inputs, including mid-conversion; a partial conversion is discarded with no done pulse.
- States and transitions: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On start=1 at edge k: capture bin into shift register, clear BCD scratch, load iteration count = W, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch nibble >= 5 gets +3, all nibbles in parallel.
  - Then shift {scratch, binreg} left by 1; the MSB of binreg enters scratch bit 0.
  - Decrement count. When the last iteration completes, go to DONE.
  - SHIFT occupies cycles k+1 .. k+W.
- DONE, cycle k+W+1:
  - done=1 and bcd/overflow/neg are updated in this same cycle (registered on the transition into DONE).
  - Next cycle: IDLE.
- Latency: done observed exactly W+1 cycles after the accepted start edge (15 for W=14).
- Throughput: a new start is accepted at the earliest in the cycle after DONE.
- start while busy=1, including during DONE: ignored, not queued.
- bin changes after capture: no effect on the conversion in progress.
- Overflow:
  - Condition: captured magnitude > 10^DIGITS - 1.
  - Effect: bcd = all nines (0x9999 for DIGITS=4) and overflow=1.
  - Otherwise overflow=0.
  - Detection uses the captured value; no extra cycles.
- bcd/overflow/neg change only in DONE or on reset; stable at all other times.
- Scratch register width: 4*DIGITS + 4, so intermediate carries beyond the top digit are visible for overflow. Overflow is also flagged if the top guard nibble is non-zero.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN
- Defined:
  - bin is two's complement.
  - At capture: if bin[W-1]=1, magnitude = -bin and neg=1 (latched in DONE); otherwise neg=0.
  - The most-negative value (-8192 for W=14) converts as 8192 with no overflow.
  - Intended to drive the display's sign input.
- Not defined:
  - bin is unsigned.
  - neg is a constant 0.
  - No negation logic is synthesised.

Test Plan:
- rst=1 for 2 cycles, then release -> busy=0, done=0, bcd=0x0000, overflow=0, neg=0.
- start with bin=1234 at edge k -> busy=1 from k+1; done=1 only at cycle k+15; bcd=0x1234, overflow=0; busy=0 at k+16.
- bin=0, then bin=9999 back-to-back, start reasserted the cycle after each done -> bcd=0x0000, then 0x9999; exactly one done pulse per conversion.
- bin=10000 (and bin=16383) -> bcd=0x9999, overflow=1; the following bin=42 conversion gives bcd=0x0042, overflow=0.
- start held high for 20 cycles with bin changing every cycle -> only the first captured value is converted; the second conversion starts the cycle after DONE.
- Mid-conversion reset: start bin=5555, rst=1 at k+7 -> no done pulse, bcd=0x0000. With BIN2BCD_SIGNED_EN defined: bin=-42 (0x3FD6) -> bcd=0x0042, neg=1; bin=-8192 -> bcd=0x8192, neg=1, overflow=0.
